// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store memory master.
//   LSU_BYTE/LSU_HALF/LSU_WORD : req_size encodings (2'b11 is illegal)
//   state_t                    : master FSM states
package lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data formatting for the LSU.
//   rd        in  memory read word (lowest byte = byte at the access address)
//   size      in  access size (LSU_BYTE/LSU_HALF/LSU_WORD)
//   uns       in  1 = zero-extend loads, 0 = sign-extend
//   wdata     in  store data from the requester
//   rdata     out extended load data
//   mem_wdata out full word to write back (sub-word stores merge into rd)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] mem_wdata
);

  always_comb begin
    rdata     = rd;
    mem_wdata = wdata;
    case (size)
      LSU_BYTE: begin
        rdata     = {{24{~uns & rd[7]}}, rd[7:0]};
        mem_wdata = {rd[31:8], wdata[7:0]};
      end
      LSU_HALF: begin
        rdata     = {{16{~uns & rd[15]}}, rd[15:0]};
        mem_wdata = {rd[31:16], wdata[15:0]};
      end
      default: begin
        rdata     = rd;
        mem_wdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator to a word-write,
// byte-addressed data memory. Byte/half stores are done as read-modify-write.
// Optional macro: MISALIGN_TRAP_EN - misaligned half/word accesses return
// rsp_err instead of being performed natively.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned     store flag, size, load zero-extend
//   req_addr, req_wdata                byte address, store data
//   rsp_valid/rsp_ready                response handshake (held until ready)
//   rsp_rdata, rsp_err                 load data (0 for stores/errors), error
//   mem_ce, mem_we, mem_addr,          memory port; zero outside RD/WR
//   mem_wdata, mem_rdata
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state, next;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_q;

  logic              req_err;
  logic              misalign;
  logic [31:0]       align_rd;
  logic [31:0]       ext_rdata;
  logic [31:0]       merge_wdata;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == LSU_HALF) && req_addr[0]) ||
                    ((req_size == LSU_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == 2'b11) || (req_addr > MAX_ADDR) || misalign;

  // Loads extend the live read word in RD; stores merge the word captured in RD.
  assign align_rd = (state == RD) ? mem_rdata : rd_q;

  lsu_align u_align (
    .rd        (align_rd),
    .size      (size_q),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .rdata     (ext_rdata),
    .mem_wdata (merge_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                            next = RESP;
          else if (req_we && req_size == LSU_WORD) next = WR;
          else                                    next = RD;
        end
      end
      RD: begin
        mem_ce   = 1'b1;
        mem_addr = addr_q;
        next     = we_q ? WR : RESP;
      end
      WR: begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = merge_wdata;
        next      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      size_q    <= LSU_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rsp_err <= req_err;
        end
        RD: begin
          rd_q <= mem_rdata;
          if (!we_q) rsp_rdata <= ext_rdata;
        end
        RESP: if (rsp_ready) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
